io_hex_display: RTL

Sequential binary-to-decimal display driver for the six on-board seven-segment digits. It sits directly downstream of the data memory's memory-mapped output port. It accepts a binary value on a one-cycle write strobe and converts it to BCD with an iterative shift-add-3 (double-dabble) engine. It then latches the result and drives hex0..hex5 with active-low segment codes, including leading-zero blanking and overflow indication.

---
 rtl/io_hex_display_if.sv | 18 +
 rtl/io_hex_display.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/io_hex_display_if.sv
// ---------------------------------------------------------------------------
// io_hex_display_if
// Write-side bus of the hex display driver.
//   wr_en   : one-cycle write strobe
//   wr_data : value to display (only the low bits are converted)
//   busy    : conversion in progress
//   done    : one-cycle pulse when the display register updates
// master = the memory-mapped port driving values in, slave = the display.
// ---------------------------------------------------------------------------
interface io_hex_display_if;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;

    modport master (output wr_en, output wr_data, input busy, input done);
    modport slave  (input wr_en, input wr_data, output busy, output done);
endinterface

// File: rtl/io_hex_display.sv
// ---------------------------------------------------------------------------
// io_hex_display
// Binary-to-decimal driver for six active-low seven-segment digits.
// A written value is converted by a double-dabble engine (one bit per
// cycle, always WIDTH cycles), latched into a display register and then
// encoded with leading-zero blanking and an overflow "dash" pattern.
// Ports:
//   clock       : single rising-edge clock
//   resetn      : asynchronous active-low reset
//   bus         : io_hex_display_if.slave (wr_en, wr_data, busy, done)
//   hex0..hex5  : segment codes, bit order gfedcba, hex0 = least significant
// ---------------------------------------------------------------------------
module io_hex_display #(
    parameter int WIDTH         = 20,
    parameter int DIGITS        = 6,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic               clock,
    input  logic               resetn,
    io_hex_display_if.slave    bus,
    output logic [6:0]         hex0,
    output logic [6:0]         hex1,
    output logic [6:0]         hex2,
    output logic [6:0]         hex3,
    output logic [6:0]         hex4,
    output logic [6:0]         hex5
);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int BW  = 4 * DIGITS;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic [BW-1:0]    disp_q, disp_d;
    logic             disp_ovf_q, disp_ovf_d;
    logic             done_q, done_d;

    logic [BW-1:0]    bcd_adj;
    logic             start_new;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] wr_val;

    assign wr_val = bus.wr_data[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^bus.wr_data[31:WIDTH];
        end
    endgenerate

    // ---------------- state register (plus datapath flops) ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            bin_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            disp_q       <= '0;
            disp_ovf_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            disp_q       <= disp_d;
            disp_ovf_q   <= disp_ovf_d;
            done_q       <= done_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.wr_en) state_d = SHIFT;
            // counter still holds 1 on the last shift; it reaches 0 with it
            SHIFT:   if (cnt_q == CW'(1)) state_d = LATCH;
            LATCH:   state_d = (bus.wr_en || pend_valid_q) ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus.busy = (state_q != IDLE);
        bus.done = done_q;
    end

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5)
                                      ? bcd_q[4*gi +: 4] + 4'd3
                                      : bcd_q[4*gi +: 4];
        end
    endgenerate

    // A fresh write in LATCH beats any older pending value.
    assign start_new = ((state_q == IDLE) && bus.wr_en) ||
                       ((state_q == LATCH) && (bus.wr_en || pend_valid_q));
    assign start_val = ((state_q == LATCH) && !bus.wr_en) ? pend_q : wr_val;

    // ---------------- datapath ----------------
    always_comb begin
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        disp_d       = disp_q;
        disp_ovf_d   = disp_ovf_q;
        done_d       = 1'b0;

        if (state_q == SHIFT) begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d          = cnt_q - CW'(1);
            if (bus.wr_en) begin
                pend_d       = wr_val;
                pend_valid_d = 1'b1;
            end
        end

        if (state_q == LATCH) begin
            disp_d       = bcd_q;
            disp_ovf_d   = ovf_q;
            done_d       = 1'b1;
            pend_valid_d = 1'b0;
        end

        if (start_new) begin
            bin_d = start_val;
            bcd_d = '0;
            cnt_d = CW'(WIDTH);
            ovf_d = (32'(start_val) > 32'd999999);
        end
    end

    // ---------------- segment encode ----------------
    function automatic logic [6:0] seg7(input logic [3:0] d);
        unique case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    logic [6:0]        seg [DIGITS];
    logic [DIGITS-1:0] lit;

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_seg
            // digit is lit if it or any digit above it is non-zero
            assign lit[gi] = |disp_q[BW-1:4*gi];
            assign seg[gi] = disp_ovf_q ? SEG_DASH :
                             (!BLANK_LEADING || gi == 0 || lit[gi])
                                 ? seg7(disp_q[4*gi +: 4]) : SEG_BLANK;
        end
    endgenerate

    assign hex0 = seg[0];
    assign hex1 = seg[1];
    assign hex2 = seg[2];
    assign hex3 = seg[3];
    assign hex4 = seg[4];
    assign hex5 = seg[5];
endmodule
